// File: rtl/chip8_mem_xfer_if.sv
// Command, register-file and memory bus signals of the CHIP-8 memory transfer unit.
// master = transfer unit, slave = surrounding core / register file / memory.
interface chip8_mem_xfer_if #(
    parameter int ADDR_W = 12
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [3:0]        cmd_count;
    logic              done;
    logic              err;
    logic [15:0]       opcode;
    logic [ADDR_W-1:0] next_addr;

    logic [3:0]        reg_rd_idx;
    logic [7:0]        reg_rd_data;
    logic              reg_we;
    logic [3:0]        reg_wr_idx;
    logic [7:0]        reg_wr_data;

    logic              mem_wren;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [7:0]        mem_write_data;
    logic              mem_reen;
    logic [ADDR_W-1:0] mem_read_addr;
    logic [7:0]        mem_read_data;
    logic              mem_read_ack;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_count,
        input  reg_rd_data, mem_read_data, mem_read_ack,
        output cmd_ready, done, err, opcode, next_addr,
        output reg_rd_idx, reg_we, reg_wr_idx, reg_wr_data,
        output mem_wren, mem_write_addr, mem_write_data, mem_reen, mem_read_addr
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_count,
        output reg_rd_data, mem_read_data, mem_read_ack,
        input  cmd_ready, done, err, opcode, next_addr,
        input  reg_rd_idx, reg_we, reg_wr_idx, reg_wr_data,
        input  mem_wren, mem_write_addr, mem_write_data, mem_reen, mem_read_addr
    );
endinterface

// File: rtl/chip8_mem_xfer.sv
// CHIP-8 memory bus master: opcode fetch, Fx55 block store and Fx65 block load,
// with a single outstanding read and a read_ack timeout.
module chip8_mem_xfer #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    chip8_mem_xfer_if.master bus
);
    localparam int WC_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_FETCH = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_HI_REQ,
        S_RD_HI_WAIT,
        S_RD_LO_REQ,
        S_RD_LO_WAIT,
        S_ST_WR,
        S_LD_REQ,
        S_LD_WAIT,
        S_LD_WR,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       opcode_q, opcode_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              reg_we_q, reg_we_d;
    logic [3:0]        reg_wr_idx_q, reg_wr_idx_d;
    logic [7:0]        reg_wr_data_q, reg_wr_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic [ADDR_W-1:0] mem_write_addr_q, mem_write_addr_d;
    logic [7:0]        mem_write_data_q, mem_write_data_d;
    logic              mem_reen_q, mem_reen_d;
    logic [ADDR_W-1:0] mem_read_addr_q, mem_read_addr_d;

    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [3:0]        count_q, count_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [7:0]        hi_q, hi_d;

    logic acc, ack, in_wait, counting, tmo, abort;

    assign acc      = (state_q == S_IDLE) && bus.cmd_valid;
    assign ack      = bus.mem_read_ack;
    assign in_wait  = state_q inside {S_RD_HI_WAIT, S_RD_LO_WAIT, S_LD_WAIT};
    // The request cycle counts toward the timeout, so the abort lands TIMEOUT cycles after reen.
    assign counting = in_wait || (state_q inside {S_RD_HI_REQ, S_RD_LO_REQ, S_LD_REQ});
    assign tmo      = in_wait && !ack && ((wcnt_q + WC_W'(1)) == WC_W'(TIMEOUT));
    assign abort    = tmo || (acc && (bus.cmd_op == OP_RSVD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    case (bus.cmd_op)
                        OP_FETCH: state_d = S_RD_HI_REQ;
                        OP_STORE: state_d = S_ST_WR;
                        OP_LOAD:  state_d = S_LD_REQ;
                        default:  state_d = S_DONE;
                    endcase
                end
            end
            S_RD_HI_REQ:  state_d = S_RD_HI_WAIT;
            S_RD_HI_WAIT: begin
                if (ack)      state_d = S_RD_LO_REQ;
                else if (tmo) state_d = S_DONE;
            end
            S_RD_LO_REQ:  state_d = S_RD_LO_WAIT;
            S_RD_LO_WAIT: begin
                if (ack || tmo) state_d = S_DONE;
            end
            S_ST_WR: begin
                if (cnt_q == ({1'b0, count_q} + 5'd1)) state_d = S_DONE;
            end
            S_LD_REQ:  state_d = S_LD_WAIT;
            S_LD_WAIT: begin
                if (ack)      state_d = S_LD_WR;
                else if (tmo) state_d = S_DONE;
            end
            S_LD_WR: begin
                if (cnt_q == {1'b0, count_q}) state_d = S_DONE;
                else                          state_d = S_LD_REQ;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the state being entered.
    always_comb begin
        op_d             = op_q;
        base_d           = base_q;
        count_d          = count_q;
        cnt_d            = cnt_q;
        wcnt_d           = wcnt_q;
        hi_d             = hi_q;
        opcode_d         = opcode_q;
        next_addr_d      = next_addr_q;
        cmd_ready_d      = (state_d == S_IDLE);
        done_d           = 1'b0;
        err_d            = 1'b0;
        mem_reen_d       = 1'b0;
        mem_read_addr_d  = mem_read_addr_q;
        mem_wren_d       = 1'b0;
        mem_write_addr_d = mem_write_addr_q;
        mem_write_data_d = mem_write_data_q;
        reg_we_d         = 1'b0;
        reg_wr_idx_d     = reg_wr_idx_q;
        reg_wr_data_d    = reg_wr_data_q;

        if (acc) begin
            op_d    = bus.cmd_op;
            base_d  = bus.cmd_addr;
            count_d = bus.cmd_count;
            cnt_d   = '0;
        end
        if (counting && !(in_wait && ack)) wcnt_d = wcnt_q + WC_W'(1);
        if ((state_q == S_RD_HI_WAIT) && ack) hi_d = bus.mem_read_data;
        if ((state_q == S_RD_LO_WAIT) && ack) opcode_d = {hi_q, bus.mem_read_data};
        if ((state_q == S_LD_WAIT) && ack) begin
            reg_wr_idx_d  = cnt_q[3:0];
            reg_wr_data_d = bus.mem_read_data;
        end
        if (state_q == S_LD_WR) cnt_d = cnt_q + 5'd1;

        case (state_d)
            S_RD_HI_REQ: begin
                mem_reen_d      = 1'b1;
                mem_read_addr_d = base_d;
                wcnt_d          = '0;
            end
            S_RD_LO_REQ: begin
                mem_reen_d      = 1'b1;
                mem_read_addr_d = base_q + ADDR_W'(1);
                wcnt_d          = '0;
            end
            S_LD_REQ: begin
                mem_reen_d      = 1'b1;
                mem_read_addr_d = base_d + ADDR_W'(cnt_d);
                wcnt_d          = '0;
            end
            // reg_rd_idx follows cnt_q, so the register byte is sampled one cycle ahead of its write.
            S_ST_WR: begin
                mem_wren_d       = 1'b1;
                mem_write_addr_d = base_d + ADDR_W'(cnt_q);
                mem_write_data_d = bus.reg_rd_data;
                cnt_d            = cnt_q + 5'd1;
            end
            S_LD_WR: reg_we_d = 1'b1;
            S_DONE: begin
                done_d      = 1'b1;
                err_d       = abort;
                next_addr_d = (op_d == OP_FETCH) ? base_d + ADDR_W'(2)
                                                 : base_d + ADDR_W'(count_d) + ADDR_W'(1);
            end
            S_IDLE:  cnt_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q      <= 1'b1;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            opcode_q         <= '0;
            next_addr_q      <= '0;
            reg_we_q         <= 1'b0;
            reg_wr_idx_q     <= '0;
            reg_wr_data_q    <= '0;
            mem_wren_q       <= 1'b0;
            mem_write_addr_q <= '0;
            mem_write_data_q <= '0;
            mem_reen_q       <= 1'b0;
            mem_read_addr_q  <= '0;
            op_q             <= '0;
            base_q           <= '0;
            count_q          <= '0;
            cnt_q            <= '0;
            wcnt_q           <= '0;
            hi_q             <= '0;
        end else begin
            cmd_ready_q      <= cmd_ready_d;
            done_q           <= done_d;
            err_q            <= err_d;
            opcode_q         <= opcode_d;
            next_addr_q      <= next_addr_d;
            reg_we_q         <= reg_we_d;
            reg_wr_idx_q     <= reg_wr_idx_d;
            reg_wr_data_q    <= reg_wr_data_d;
            mem_wren_q       <= mem_wren_d;
            mem_write_addr_q <= mem_write_addr_d;
            mem_write_data_q <= mem_write_data_d;
            mem_reen_q       <= mem_reen_d;
            mem_read_addr_q  <= mem_read_addr_d;
            op_q             <= op_d;
            base_q           <= base_d;
            count_q          <= count_d;
            cnt_q            <= cnt_d;
            wcnt_q           <= wcnt_d;
            hi_q             <= hi_d;
        end
    end

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.opcode         = opcode_q;
    assign bus.next_addr      = next_addr_q;
    assign bus.reg_rd_idx     = cnt_q[3:0];
    assign bus.reg_we         = reg_we_q;
    assign bus.reg_wr_idx     = reg_wr_idx_q;
    assign bus.reg_wr_data    = reg_wr_data_q;
    assign bus.mem_wren       = mem_wren_q;
    assign bus.mem_write_addr = mem_write_addr_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_reen       = mem_reen_q;
    assign bus.mem_read_addr  = mem_read_addr_q;
endmodule

// File: tb/tb_chip8_mem_xfer.sv
// Bench for chip8_mem_xfer: memory/register-file models, directed cases and random commands.
module tb_chip8_mem_xfer;
    localparam int AW  = 12;
    localparam int TMO = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chip8_mem_xfer_if #(.ADDR_W(AW)) bus ();
    chip8_mem_xfer #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem  [0:4095];
    logic [7:0] vreg [0:15];
    always_comb bus.reg_rd_data = vreg[bus.reg_rd_idx];

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;

    // memory read port: ack 'stall' edges after the reen edge; read number drop_at never acks
    int stall   = 0;
    int drop_at = -1;
    int rd_num  = 0;
    logic pend  = 1'b0;
    int sc      = 0;
    logic [AW-1:0] paddr = '0;

    always @(posedge clk) begin
        bus.mem_read_ack <= 1'b0;
        if (pend) begin
            if (sc == 0) begin
                bus.mem_read_ack  <= 1'b1;
                bus.mem_read_data <= mem[paddr];
                pend <= 1'b0;
            end else begin
                sc <= sc - 1;
            end
        end
        if (bus.mem_reen) begin
            if (rd_num != drop_at) begin
                if (stall == 0) begin
                    bus.mem_read_ack  <= 1'b1;
                    bus.mem_read_data <= mem[bus.mem_read_addr];
                end else begin
                    pend  <= 1'b1;
                    sc    <= stall - 1;
                    paddr <= bus.mem_read_addr;
                end
            end
            rd_num <= rd_num + 1;
        end
        if (!rst_n) pend <= 1'b0;
    end

    int rd_a[$], rd_c[$], wr_a[$], wr_d[$], wr_c[$], rw_i[$], rw_d[$];
    int overlap = 0, repeat_cnt = 0, done_cnt = 0;
    logic prev_reen = 1'b0, prev_we = 1'b0, prev_done = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_reen) begin
            rd_a.push_back(int'(bus.mem_read_addr));
            rd_c.push_back(int'(cyc));
        end
        if (bus.mem_wren) begin
            wr_a.push_back(int'(bus.mem_write_addr));
            wr_d.push_back(int'(bus.mem_write_data));
            wr_c.push_back(int'(cyc));
        end
        if (bus.reg_we) begin
            rw_i.push_back(int'(bus.reg_wr_idx));
            rw_d.push_back(int'(bus.reg_wr_data));
        end
        if (int'(bus.mem_reen) + int'(bus.mem_wren) + int'(bus.reg_we) > 1) overlap <= overlap + 1;
        if ((bus.mem_reen && prev_reen) || (bus.reg_we && prev_we) || (bus.done && prev_done))
            repeat_cnt <= repeat_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
        prev_reen <= bus.mem_reen;
        prev_we   <= bus.reg_we;
        prev_done <= bus.done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_a.delete(); rd_c.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
        rw_i.delete(); rw_d.delete();
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [3:0] cnt,
                           output int acc_c, output int done_c, output logic e,
                           output logic [AW-1:0] na);
        logic got;
        got = 1'b0; acc_c = -1; done_c = -1; e = 1'bx; na = 'x;
        clear_logs();
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_count = cnt;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.cmd_ready) begin got = 1'b1; acc_c = int'(cyc); end
            else @(negedge clk);
        end
        chk("accept", 32'(got), 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (bus.done) begin
                got = 1'b1; done_c = int'(cyc); e = bus.err; na = bus.next_addr;
            end else @(negedge clk);
        end
        chk("done_seen", 32'(got), 1);
        @(negedge clk);
    endtask

    // Runs one command and checks everything observable against the transfer rules.
    task automatic do_cmd(input string nm, input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [3:0] x, input int s);
        int acc_c, done_c, n, ai;
        logic e;
        logic [AW-1:0] na;
        stall = s;
        ai = int'(a);
        n = int'(x) + 1;
        run_cmd(op, a, x, acc_c, done_c, e, na);
        chk({nm, ".err"}, 32'(e), 0);
        case (op)
            2'd0: begin
                chk({nm, ".opcode"}, 32'(bus.opcode), {16'h0, mem[ai], mem[(ai + 1) % 4096]});
                chk({nm, ".next"}, 32'(na), (ai + 2) % 4096);
                chk({nm, ".lat"}, done_c - acc_c, 5 + 2 * s);
                chk({nm, ".nrd"}, rd_a.size(), 2);
                for (int k = 0; k < rd_a.size() && k < 2; k++)
                    chk({nm, ".rdaddr"}, rd_a[k], (ai + k) % 4096);
                chk({nm, ".nwr"}, wr_a.size() + rw_i.size(), 0);
            end
            2'd1: begin
                chk({nm, ".next"}, 32'(na), (ai + n) % 4096);
                chk({nm, ".lat"}, done_c - acc_c, n + 1);
                chk({nm, ".nwr"}, wr_a.size(), n);
                for (int k = 0; k < wr_a.size() && k < n; k++) begin
                    chk({nm, ".wraddr"}, wr_a[k], (ai + k) % 4096);
                    chk({nm, ".wrdata"}, wr_d[k], int'(vreg[k]));
                    chk({nm, ".wrcyc"}, wr_c[k], acc_c + 1 + k);
                end
                chk({nm, ".nrd"}, rd_a.size() + rw_i.size(), 0);
            end
            default: begin
                chk({nm, ".next"}, 32'(na), (ai + n) % 4096);
                chk({nm, ".lat"}, done_c - acc_c, n * (3 + s) + 1);
                chk({nm, ".nrw"}, rw_i.size(), n);
                chk({nm, ".nrd"}, rd_a.size(), n);
                for (int k = 0; k < rw_i.size() && k < n; k++) begin
                    chk({nm, ".rwidx"}, rw_i[k], k);
                    chk({nm, ".rwdata"}, rw_d[k], int'(mem[(ai + k) % 4096]));
                end
                for (int k = 0; k < rd_a.size() && k < n; k++)
                    chk({nm, ".rdaddr"}, rd_a[k], (ai + k) % 4096);
                chk({nm, ".nwr"}, wr_a.size(), 0);
            end
        endcase
    endtask

    initial begin
        int acc_c, done_c, d0;
        logic e;
        logic [AW-1:0] na;
        logic seen;

        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_count = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) vreg[i] = 8'($urandom);

        #12;
        chk("rst.ready", 32'(bus.cmd_ready), 1);
        chk("rst.done", 32'(bus.done), 0);
        chk("rst.err", 32'(bus.err), 0);
        chk("rst.opcode", 32'(bus.opcode), 0);
        chk("rst.next", 32'(bus.next_addr), 0);
        chk("rst.strobes", {29'h0, bus.mem_reen, bus.mem_wren, bus.reg_we}, 0);
        chk("rst.rdidx", 32'(bus.reg_rd_idx), 0);
        chk("rst.rdaddr", 32'(bus.mem_read_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        mem[12'h200] = 8'h6A; mem[12'h201] = 8'h0F;
        do_cmd("f200", 2'd0, 12'h200, 4'd0, 0);
        chk("f200.lit", 32'(bus.opcode), 32'h6A0F);

        mem[12'hFFF] = 8'h12; mem[12'h000] = 8'h34;
        do_cmd("ffff", 2'd0, 12'hFFF, 4'd0, 0);
        chk("ffff.lit", 32'(bus.opcode), 32'h1234);

        vreg[0] = 8'h11; vreg[1] = 8'h22; vreg[2] = 8'h33; vreg[3] = 8'h44;
        do_cmd("st300", 2'd1, 12'h300, 4'd3, 0);

        do_cmd("ld3fe", 2'd2, 12'h3FE, 4'd2, 3);
        chk("ld3fe.opcode_hold", 32'(bus.opcode), 32'h1234);

        stall = 0;
        drop_at = rd_num + 1;
        run_cmd(2'd2, 12'h500, 4'd1, acc_c, done_c, e, na);
        drop_at = -1;
        chk("tmo.err", 32'(e), 1);
        chk("tmo.nrw", rw_i.size(), 1);
        if (rw_i.size() > 0) begin
            chk("tmo.rwidx", rw_i[0], 0);
            chk("tmo.rwdata", rw_d[0], int'(mem[12'h500]));
        end
        chk("tmo.nrd", rd_a.size(), 2);
        if (rd_c.size() > 1) chk("tmo.lat", done_c - rd_c[1], TMO);

        run_cmd(2'd3, 12'h123, 4'd5, acc_c, done_c, e, na);
        chk("rsvd.err", 32'(e), 1);
        chk("rsvd.lat", done_c - acc_c, 1);
        chk("rsvd.strobes", rd_a.size() + wr_a.size() + rw_i.size(), 0);

        clear_logs();
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_addr = 12'h700; bus.cmd_count = 4'd7;
        chk("abort.ready", 32'(bus.cmd_ready), 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (wr_a.size() >= 2) seen = 1'b1;
            else @(negedge clk);
        end
        chk("abort.two_bytes", wr_a.size(), 2);
        rst_n = 1'b0;
        #1;
        chk("abort.strobes", {29'h0, bus.mem_reen, bus.mem_wren, bus.reg_we}, 0);
        chk("abort.done", {30'h0, bus.done, bus.err}, 0);
        chk("abort.ready_rst", 32'(bus.cmd_ready), 1);
        chk("abort.wraddr", 32'(bus.mem_write_addr), 0);
        chk("abort.wrdata", 32'(bus.mem_write_data), 0);
        chk("abort.rdidx", 32'(bus.reg_rd_idx), 0);
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        chk("abort.nwr", wr_a.size(), 2);
        chk("abort.nodone", done_cnt, d0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort.ready", 32'(bus.cmd_ready), 1);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 16; i++) vreg[i] = 8'($urandom);
            do_cmd($sformatf("rnd%0d", t), 2'($urandom_range(2, 0)), AW'($urandom),
                   4'($urandom), int'($urandom_range(2, 0)));
        end

        chk("strobe_overlap", overlap, 0);
        chk("strobe_repeat", repeat_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
